// File: rtl/mux2to1_pipe.sv
// Parameterised 2:1 selector: combinational o_Y plus a valid-tagged registered copy o_Y_q.
// Latency: o_Y is 0 cycles; o_Y_q/o_valid arrive PIPE_STAGES cycles after acceptance (0 = combinational).
// Backpressure: none; one item is accepted every cycle that i_valid=1. Optional MUX2TO1_PIPE_SEL_STATS_EN adds select counters.
module mux2to1_pipe #(
    parameter int          WIDTH       = 1,
    parameter int          PIPE_STAGES = 1,
    parameter logic [63:0] RST_VAL     = 64'd0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_X0,
    input  logic [WIDTH-1:0] i_X1,
    input  logic             i_sel,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_Y,
    output logic [WIDTH-1:0] o_Y_q,
    output logic             o_valid
`ifdef MUX2TO1_PIPE_SEL_STATS_EN
    ,
    output logic [15:0]      o_sel1_cnt,
    output logic [15:0]      o_sel0_cnt
`endif
);

    localparam logic [WIDTH-1:0] W_RST = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] w_y;

    // Bitwise steering; no clock or reset involvement.
    always_comb begin
        w_y = i_sel ? i_X1 : i_X0;
    end

    assign o_Y = w_y;

    generate
        if (PIPE_STAGES == 0) begin : g_comb
            // No registers at all: the "registered" path is a straight wire.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_rst;
            assign o_Y_q   = w_y;
            assign o_valid = i_valid;
        end else begin : g_pipe
            logic [WIDTH-1:0]       r_dat [PIPE_STAGES];
            logic [PIPE_STAGES-1:0] r_vld;

            // Valid bits shift every cycle; each data stage loads only when its upstream is valid.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int n = 0; n < PIPE_STAGES; n++) begin
                        r_dat[n] <= W_RST;
                    end
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= i_valid;
                    if (i_valid) begin
                        r_dat[0] <= w_y;
                    end
                    for (int n = 1; n < PIPE_STAGES; n++) begin
                        r_vld[n] <= r_vld[n-1];
                        if (r_vld[n-1]) begin
                            r_dat[n] <= r_dat[n-1];
                        end
                    end
                end
            end

            assign o_Y_q   = r_dat[PIPE_STAGES-1];
            assign o_valid = r_vld[PIPE_STAGES-1];
        end
    endgenerate

`ifdef MUX2TO1_PIPE_SEL_STATS_EN
    logic [15:0] r_sel1_cnt;
    logic [15:0] r_sel0_cnt;

    // Saturating per-select counts of accepted items; reset wins over acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel1_cnt <= 16'd0;
            r_sel0_cnt <= 16'd0;
        end else if (i_valid) begin
            if (i_sel && (r_sel1_cnt != 16'hFFFF)) begin
                r_sel1_cnt <= r_sel1_cnt + 16'd1;
            end
            if (!i_sel && (r_sel0_cnt != 16'hFFFF)) begin
                r_sel0_cnt <= r_sel0_cnt + 16'd1;
            end
        end
    end

    assign o_sel1_cnt = r_sel1_cnt;
    assign o_sel0_cnt = r_sel0_cnt;
`endif

endmodule

// File: tb/tb_mux2to1_pipe.sv
// Directed bench for mux2to1_pipe: three instances cover WIDTH=1/1 stage, WIDTH=8/2 stages, WIDTH=8/0 stages.
// Inputs change away from the rising edge; outputs are sampled at the falling edge or after a small delay.
// Expected values are hand-computed constants.
module tb_mux2to1_pipe;

    logic clk = 1'b0;
    logic rst;

    // WIDTH=1 instance stimulus
    logic a_x0, a_x1, a_sel;
    logic a_y, a_yq, a_vld;

    // WIDTH=8 instances share stimulus
    logic [7:0] x0, x1;
    logic       sel, valid;
    logic [7:0] b_y, b_yq, c_y, c_yq;
    logic       b_vld, c_vld;

`ifdef MUX2TO1_PIPE_SEL_STATS_EN
    logic [15:0] a_c1, a_c0, b_c1, b_c0, c_c1, c_c0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2to1_pipe #(.WIDTH(1), .PIPE_STAGES(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_X0(a_x0), .i_X1(a_x1), .i_sel(a_sel), .i_valid(valid),
        .o_Y(a_y), .o_Y_q(a_yq), .o_valid(a_vld)
`ifdef MUX2TO1_PIPE_SEL_STATS_EN
        , .o_sel1_cnt(a_c1), .o_sel0_cnt(a_c0)
`endif
    );

    mux2to1_pipe #(.WIDTH(8), .PIPE_STAGES(2), .RST_VAL(64'h5A)) u_b (
        .i_clk(clk), .i_rst(rst), .i_X0(x0), .i_X1(x1), .i_sel(sel), .i_valid(valid),
        .o_Y(b_y), .o_Y_q(b_yq), .o_valid(b_vld)
`ifdef MUX2TO1_PIPE_SEL_STATS_EN
        , .o_sel1_cnt(b_c1), .o_sel0_cnt(b_c0)
`endif
    );

    mux2to1_pipe #(.WIDTH(8), .PIPE_STAGES(0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_X0(x0), .i_X1(x1), .i_sel(sel), .i_valid(valid),
        .o_Y(c_y), .o_Y_q(c_yq), .o_valid(c_vld)
`ifdef MUX2TO1_PIPE_SEL_STATS_EN
        , .o_sel1_cnt(c_c1), .o_sel0_cnt(c_c0)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_s0 [4];
        logic exp_s1 [4];
        logic [1:0] pat;
        exp_s0 = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_s1 = '{1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; valid = 1'b0; sel = 1'b0; x0 = 8'h00; x1 = 8'h00;
        a_x0 = 1'b0; a_x1 = 1'b0; a_sel = 1'b0;

        // WIDTH=1 combinational sweep, sel=0 then sel=1
        for (int i = 0; i < 4; i++) begin
            pat = i[1:0];
            {a_x1, a_x0} = pat;
            #10 chk($sformatf("comb_sel0_%0d", i), 64'(a_y), 64'(exp_s0[i]));
        end
        a_sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pat = i[1:0];
            {a_x1, a_x0} = pat;
            #10 chk($sformatf("comb_sel1_%0d", i), 64'(a_y), 64'(exp_s1[i]));
        end

        // Reset state (reset held across several edges)
        @(negedge clk);
        chk("rst_b_yq", 64'(b_yq), 64'h5A);
        chk("rst_b_vld", 64'(b_vld), 64'h0);
        chk("rst_a_yq", 64'(a_yq), 64'h0);
        chk("rst_a_vld", 64'(a_vld), 64'h0);

        // WIDTH=8 toggling with no clock edge in between
        x0 = 8'hA5; x1 = 8'h3C; sel = 1'b0;
        #1 chk("w8_sel0", 64'(b_y), 64'hA5);
        chk("p0_yq_sel0", 64'(c_yq), 64'hA5);
        sel = 1'b1;
        #1 chk("w8_sel1", 64'(b_y), 64'h3C);
        chk("p0_yq_sel1", 64'(c_yq), 64'h3C);
        sel = 1'b0;
        #1 chk("w8_sel0b", 64'(b_y), 64'hA5);
        chk("p0_yq_sel0b", 64'(c_yq), 64'hA5);

        // Latency: single item through 2 stages (u_b) and 1 stage (u_a)
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        valid = 1'b1; sel = 1'b1; x1 = 8'h3C;
        a_sel = 1'b0; a_x0 = 1'b1; a_x1 = 1'b0;
        #1 chk("p0_vld_follow", 64'(c_vld), 64'h1);
        @(negedge clk);
        valid = 1'b0; sel = 1'b0; a_sel = 1'b1;
        #1 chk("p0_vld_drop", 64'(c_vld), 64'h0);
        chk("lat_b_edge1_vld", 64'(b_vld), 64'h0);
        chk("lat_a_edge1_vld", 64'(a_vld), 64'h1);
        chk("lat_a_edge1_yq", 64'(a_yq), 64'h1);
        @(negedge clk);
        chk("lat_b_edge2_vld", 64'(b_vld), 64'h1);
        chk("lat_b_edge2_yq", 64'(b_yq), 64'h3C);
        chk("lat_a_after_vld", 64'(a_vld), 64'h0);
        chk("lat_a_hold_yq", 64'(a_yq), 64'h1);
        @(negedge clk);
        chk("lat_b_after_vld", 64'(b_vld), 64'h0);
        chk("lat_b_hold_yq", 64'(b_yq), 64'h3C);

        // Back-to-back items, full throughput
        valid = 1'b1; sel = 1'b0; x0 = 8'h11;
        @(negedge clk); x0 = 8'h22;
        @(negedge clk); x0 = 8'h33;
        chk("b2b_1_yq", 64'(b_yq), 64'h11);
        chk("b2b_1_vld", 64'(b_vld), 64'h1);
        @(negedge clk); valid = 1'b0; sel = 1'b1;
        chk("b2b_2_yq", 64'(b_yq), 64'h22);
        chk("b2b_2_vld", 64'(b_vld), 64'h1);
        @(negedge clk);
        chk("b2b_3_yq", 64'(b_yq), 64'h33);
        chk("b2b_3_vld", 64'(b_vld), 64'h1);
        @(negedge clk);
        chk("b2b_end_yq", 64'(b_yq), 64'h33);
        chk("b2b_end_vld", 64'(b_vld), 64'h0);

        // Reset mid-flight, with a valid input colliding with reset
        valid = 1'b1; sel = 1'b0; x0 = 8'h77;
        @(negedge clk);
        rst = 1'b1; x0 = 8'h99;
        #1 chk("p0_rst_yq", 64'(c_yq), 64'h99);
        chk("p0_rst_vld", 64'(c_vld), 64'h1);
        chk("rst_no_effect_y", 64'(b_y), 64'h99);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        chk("midrst_yq", 64'(b_yq), 64'h5A);
        chk("midrst_vld", 64'(b_vld), 64'h0);
        @(negedge clk);
        chk("midrst_stale1_vld", 64'(b_vld), 64'h0);
        @(negedge clk);
        chk("midrst_stale2_vld", 64'(b_vld), 64'h0);
        chk("midrst_stale2_yq", 64'(b_yq), 64'h5A);

`ifdef MUX2TO1_PIPE_SEL_STATS_EN
        chk("cnt_rst_sel1", 64'(b_c1), 64'h0);
        chk("cnt_rst_sel0", 64'(b_c0), 64'h0);
        valid = 1'b1; sel = 1'b1;
        repeat (5) @(negedge clk);
        sel = 1'b0;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("cnt_sel1_5", 64'(b_c1), 64'd5);
        chk("cnt_sel0_3", 64'(b_c0), 64'd3);
        valid = 1'b1; sel = 1'b1;
        repeat (65532) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("cnt_sat", 64'(b_c1), 64'hFFFF);
        chk("cnt_sel0_hold", 64'(b_c0), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
